// File: rtl/banco_registros_multipuerto.sv
// Multiport register file: N entries of K bits, one write port, two registered read ports
// and a per-entry pending scoreboard. Define BANCO_BYPASS_EN to forward same-edge writes to the read ports.
module banco_registros_multipuerto #(
   parameter int K        = 12,
   parameter int N        = 8,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(N)
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic          WE,
   input  logic [AW-1:0] WAddr,
   input  logic [K-1:0]  WData,
   input  logic          Mark,
   input  logic [AW-1:0] MAddr,
   input  logic [AW-1:0] RAddrA,
   input  logic [AW-1:0] RAddrB,
   output logic [K-1:0]  QA,
   output logic [K-1:0]  QB,
   output logic          BusyA,
   output logic          BusyB
);

   localparam logic [AW:0] NumEntries = (AW+1)'(N);

   logic [K-1:0] mem_q [N];
   logic [K-1:0] mem_d [N];
   logic [N-1:0] pend_q, pend_d;
   logic [K-1:0] qA_q, qA_d, qB_q, qB_d;
   logic         busyA_q, busyA_d, busyB_q, busyB_d;
   logic         wrEn, mkEn;

   // An address is live when it names a real entry that is not the hardwired zero register
   function automatic logic addrLive(input logic [AW-1:0] addr);
      return ({1'b0, addr} < NumEntries) && !((ZERO_REG != 0) && (addr == '0));
   endfunction

   // Returns {pending, data} as seen by a read port at this edge
   function automatic logic [K:0] readEntry(input logic [AW-1:0] addr);
      logic [K:0] r;
      r = '0;
      if (addrLive(addr)) begin
         r = {pend_q[addr], mem_q[addr]};
`ifdef BANCO_BYPASS_EN
         if (wrEn && (addr == WAddr))
            r = {mkEn && (MAddr == addr), WData};
`endif
      end
      return r;
   endfunction

   // Mark is applied after the write so a same-edge mark leaves the entry pending
   always_comb begin
      wrEn   = WE && addrLive(WAddr);
      mkEn   = Mark && addrLive(MAddr);
      mem_d  = mem_q;
      pend_d = pend_q;
      if (wrEn) begin
         mem_d[WAddr]  = WData;
         pend_d[WAddr] = 1'b0;
      end
      if (mkEn)
         pend_d[MAddr] = 1'b1;
   end

   always_comb begin
      {busyA_d, qA_d} = readEntry(RAddrA);
      {busyB_d, qB_d} = readEntry(RAddrB);
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         for (int i = 0; i < N; i++)
            mem_q[i] <= '0;
         pend_q  <= '0;
         qA_q    <= '0;
         qB_q    <= '0;
         busyA_q <= 1'b0;
         busyB_q <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         pend_q  <= pend_d;
         qA_q    <= qA_d;
         qB_q    <= qB_d;
         busyA_q <= busyA_d;
         busyB_q <= busyB_d;
      end
   end

   assign QA    = qA_q;
   assign QB    = qB_q;
   assign BusyA = busyA_q;
   assign BusyB = busyB_q;

endmodule

// File: tb/tb_banco_registros_multipuerto.sv
// Directed self-checking bench for banco_registros_multipuerto: an N=8 instance and an
// N=6 instance share all inputs so invalid-address behaviour can be checked too.
module tb_banco_registros_multipuerto;

   logic        CLK = 1'b0;
   logic        Reset, WE, Mark;
   logic [2:0]  WAddr, MAddr, RAddrA, RAddrB;
   logic [11:0] WData;
   logic [11:0] QA, QB, sQA, sQB;
   logic        BusyA, BusyB, sBusyA, sBusyB;

   int errCount   = 0;
   int checkCount = 0;

   logic [11:0] smallExp [6];
   logic        smallPend [6];

   always #5 CLK = ~CLK;

   banco_registros_multipuerto #(.K(12), .N(8), .ZERO_REG(1)) dutMain (
      .CLK(CLK), .Reset(Reset), .WE(WE), .WAddr(WAddr), .WData(WData),
      .Mark(Mark), .MAddr(MAddr), .RAddrA(RAddrA), .RAddrB(RAddrB),
      .QA(QA), .QB(QB), .BusyA(BusyA), .BusyB(BusyB)
   );

   banco_registros_multipuerto #(.K(12), .N(6), .ZERO_REG(1)) dutSmall (
      .CLK(CLK), .Reset(Reset), .WE(WE), .WAddr(WAddr), .WData(WData),
      .Mark(Mark), .MAddr(MAddr), .RAddrA(RAddrA), .RAddrB(RAddrB),
      .QA(sQA), .QB(sQB), .BusyA(sBusyA), .BusyB(sBusyB)
   );

   // Drives one cycle of inputs, lets the rising edge pass, then settles before sampling
   task automatic applyStimulus(input logic rst, input logic we, input logic [2:0] wa,
                                input logic [11:0] wd, input logic mk, input logic [2:0] ma,
                                input logic [2:0] ra, input logic [2:0] rb);
      Reset  = rst;
      WE     = we;
      WAddr  = wa;
      WData  = wd;
      Mark   = mk;
      MAddr  = ma;
      RAddrA = ra;
      RAddrB = rb;
      @(posedge CLK);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      applyStimulus(1'b1, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 3'd0, 3'd0);
      checkOutput("rst_QA", 32'(QA), 32'h0);
      checkOutput("rst_QB", 32'(QB), 32'h0);
      checkOutput("rst_BusyA", 32'(BusyA), 32'h0);
      checkOutput("rst_BusyB", 32'(BusyB), 32'h0);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 3'(i), 3'(7 - i));
         checkOutput("rdall_QA", 32'(QA), 32'h0);
         checkOutput("rdall_QB", 32'(QB), 32'h0);
         checkOutput("rdall_Busy", 32'({BusyA, BusyB}), 32'h0);
      end

      applyStimulus(1'b0, 1'b1, 3'd3, 12'hABC, 1'b0, 3'd0, 3'd0, 3'd0);
      applyStimulus(1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 3'd3, 3'd3);
      checkOutput("wr3_QA", 32'(QA), 32'hABC);
      checkOutput("wr3_QB", 32'(QB), 32'hABC);
      checkOutput("wr3_Busy", 32'({BusyA, BusyB}), 32'h0);

      applyStimulus(1'b0, 1'b0, 3'd0, 12'h000, 1'b1, 3'd5, 3'd0, 3'd0);
      applyStimulus(1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 3'd5, 3'd3);
      checkOutput("mark5_BusyA", 32'(BusyA), 32'h1);
      checkOutput("mark5_QA", 32'(QA), 32'h0);
      checkOutput("mark5_BusyB", 32'(BusyB), 32'h0);

      applyStimulus(1'b0, 1'b1, 3'd5, 12'h123, 1'b0, 3'd0, 3'd0, 3'd0);
      applyStimulus(1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 3'd5, 3'd0);
      checkOutput("wr5_QA", 32'(QA), 32'h123);
      checkOutput("wr5_BusyA", 32'(BusyA), 32'h0);

      applyStimulus(1'b0, 1'b1, 3'd2, 12'h2AA, 1'b1, 3'd2, 3'd0, 3'd0);
      applyStimulus(1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 3'd2, 3'd2);
      checkOutput("mkwr2_QA", 32'(QA), 32'h2AA);
      checkOutput("mkwr2_BusyA", 32'(BusyA), 32'h1);
      checkOutput("mkwr2_BusyB", 32'(BusyB), 32'h1);

      applyStimulus(1'b0, 1'b1, 3'd4, 12'h111, 1'b0, 3'd0, 3'd0, 3'd0);
      applyStimulus(1'b0, 1'b1, 3'd4, 12'h0F0, 1'b0, 3'd0, 3'd4, 3'd0);
`ifdef BANCO_BYPASS_EN
      checkOutput("rdw4_QA", 32'(QA), 32'h0F0);
`else
      checkOutput("rdw4_QA", 32'(QA), 32'h111);
`endif
      checkOutput("rdw4_BusyA", 32'(BusyA), 32'h0);
      applyStimulus(1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 3'd4, 3'd0);
      checkOutput("after4_QA", 32'(QA), 32'h0F0);

      applyStimulus(1'b0, 1'b1, 3'd6, 12'h0AA, 1'b1, 3'd6, 3'd0, 3'd6);
`ifdef BANCO_BYPASS_EN
      checkOutput("rdwmk6_QB", 32'(QB), 32'h0AA);
      checkOutput("rdwmk6_BusyB", 32'(BusyB), 32'h1);
`else
      checkOutput("rdwmk6_QB", 32'(QB), 32'h0);
      checkOutput("rdwmk6_BusyB", 32'(BusyB), 32'h0);
`endif
      checkOutput("small6_QB", 32'(sQB), 32'h0);
      checkOutput("small6_BusyB", 32'(sBusyB), 32'h0);

      applyStimulus(1'b0, 1'b1, 3'd0, 12'hFFF, 1'b1, 3'd0, 3'd0, 3'd6);
      checkOutput("zero_same_QA", 32'(QA), 32'h0);
      checkOutput("main6_QB", 32'(QB), 32'h0AA);
      checkOutput("main6_BusyB", 32'(BusyB), 32'h1);
      applyStimulus(1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 3'd0, 3'd0);
      checkOutput("zero_QA", 32'(QA), 32'h0);
      checkOutput("zero_Busy", 32'({BusyA, BusyB}), 32'h0);

      applyStimulus(1'b0, 1'b1, 3'd7, 12'h777, 1'b1, 3'd7, 3'd0, 3'd0);
      applyStimulus(1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 3'd7, 3'd7);
      checkOutput("main7_QA", 32'(QA), 32'h777);
      checkOutput("main7_BusyA", 32'(BusyA), 32'h1);
      checkOutput("small7_QA", 32'(sQA), 32'h0);
      checkOutput("small7_Busy", 32'({sBusyA, sBusyB}), 32'h0);

      smallExp  = '{12'h000, 12'h000, 12'h2AA, 12'hABC, 12'h0F0, 12'h123};
      smallPend = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 3'(i), 3'd0);
         checkOutput("small_QA", 32'(sQA), 32'(smallExp[i]));
         checkOutput("small_BusyA", 32'(sBusyA), 32'(smallPend[i]));
      end

      applyStimulus(1'b1, 1'b1, 3'd1, 12'h555, 1'b1, 3'd1, 3'd3, 3'd2);
      checkOutput("midrst_QA", 32'(QA), 32'h0);
      checkOutput("midrst_QB", 32'(QB), 32'h0);
      checkOutput("midrst_Busy", 32'({BusyA, BusyB}), 32'h0);
      applyStimulus(1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 3'd1, 3'd2);
      checkOutput("post_rst1_QA", 32'(QA), 32'h0);
      checkOutput("post_rst2_QB", 32'(QB), 32'h0);
      checkOutput("post_rst_Busy", 32'({BusyA, BusyB}), 32'h0);
      applyStimulus(1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 3'd7, 3'd3);
      checkOutput("post_rst7_QA", 32'(QA), 32'h0);
      checkOutput("post_rst3_QB", 32'(QB), 32'h0);
      checkOutput("post_rst7_BusyA", 32'(BusyA), 32'h0);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule

// File: doc/banco_registros_multipuerto.md
# banco_registros_multipuerto

Parametrised register file for the datapath: N entries of K bits each, with one write port, two registered read ports and a per-entry pending scoreboard. It replaces flat per-bit flip-flop banks wherever the datapath must address several registers, such as the operand file feeding the ALU. Pending bits let the control unit stall on operands whose producer has not written back yet.

## Interface
Parameters:
- K, 12, data width in bits (≥1).
- N, 8, number of entries (≥2; need not be a power of two).
- ZERO_REG, 1, when 1, entry 0 is hardwired to zero, ignores writes and is never pending.
- AW, localparam = $clog2(N), address width.

Ports:
- CLK  input  1  single clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset, sampled on the rising CLK edge.
- WE  input  1  write enable.
- WAddr  input  AW  write address.
- WData  input  K  write data.
- Mark  input  1  set the pending bit of MAddr.
- MAddr  input  AW  address to mark pending.
- RAddrA  input  AW  read port A address.
- RAddrB  input  AW  read port B address.
- QA  output  K  port A data, registered.
- QB  output  K  port B data, registered.
- BusyA  output  1  pending bit of the port A address, registered alongside QA.
- BusyB  output  1  pending bit of the port B address, registered alongside QB.

## Operation
- Reset: at the edge where Reset=1, clear all entries, all pending bits, QA, QB, BusyA and BusyB to 0. Reset overrides WE and Mark in that cycle.
- Write: WE=1 at an edge with a valid WAddr stores WData and clears the pending bit of WAddr.
- Mark: Mark=1 at an edge with a valid MAddr sets pending[MAddr].
- Mark and write to the same address at the same edge: the entry takes WData and the pending bit ends at 1 (Mark wins).
- Read: at each edge, QA takes entry[RAddrA] and BusyA takes pending[RAddrA]. Port B behaves the same way. Both ports are independent and may use the same address.
- Invalid address (≥N):
  - A write or mark to it is ignored.
  - A read from it returns Q=0 and Busy=0.
- ZERO_REG=1:
  - A write or mark to address 0 is ignored.
  - A read of address 0 returns Q=0 and Busy=0.
- Read during write to the same address: depends on BANCO_BYPASS_EN (see Configuration).

## Timing
- Read latency is 1 cycle: the address is sampled at edge t, and QA/BusyA are valid after edge t and hold until edge t+1.
- Write latency is 1 cycle: data written at edge t is visible on Q after edge t+1 with no bypass, or after edge t with bypass.
- Outputs never change between edges. No combinational path exists from any input to any output.
- Reset asserted mid-stream: the outputs read 0 after that edge. Any write or mark presented in the same cycle is lost.

## Configuration
- Macro: BANCO_BYPASS_EN.
- Defined: a read at edge t of an address being written at edge t returns WData. Busy then reflects the post-edge pending value: 0, or 1 if Mark targets the same address in that cycle.
- Undefined: the same read returns the old entry contents and the old pending bit.
- ZERO_REG and invalid-address rules apply before the bypass in both cases.

## Test plan
- Reset then read: assert Reset for one edge, then read every address on both ports -> every QA/QB=0 and every BusyA/BusyB=0.
- Basic write/read (K=12, N=8): write 0xABC to address 3, then read RAddrA=3 and RAddrB=3 on the next edge -> QA=QB=0xABC with Busy=0.
- Scoreboard:
  - Mark address 5, then read address 5 -> BusyA=1.
  - Write 0x123 to address 5, then read it -> QA=0x123 and BusyA=0.
  - Mark and write address 2 in the same cycle, then read -> Busy=1 with the new data.
- Same-edge read/write: write 0x0F0 to address 4 (old value 0x111) while reading address 4 -> QA=0x0F0 with BANCO_BYPASS_EN defined, QA=0x111 without it.
- Zero and invalid addresses:
  - ZERO_REG=1: write 0xFFF to address 0 -> read returns 0.
  - N=6: write to address 7 -> no entry changes, and reading address 7 returns Q=0, Busy=0.
- Reset mid-operation: hold WE=1 (data 0x555 to address 1) and Reset=1 on the same edge -> address 1 reads 0 and all Busy outputs are 0.
